// File: rtl/ioddr_xfer.sv
`timescale 1ns/1ps
// ioddr_xfer: DDR bidirectional pad block for a shared DQ bus.
// A small FSM owns the bus direction (IDLE/TX/RX/TURN). TX words are accepted
// with valid/ready and driven on both clock phases. RX words are captured on
// negedge (high half) and the following posedge (low half), then delayed
// through a RX_LATENCY-deep valid pipeline.
// Optional build macro IODDR_LOOPBACK_EN adds an lpbk input. While lpbk is
// high, dq is never driven and the capture source is the internal TX output
// register.
module ioddr_xfer #(
    parameter int WIDTH      = 8,
    parameter int TURNAROUND = 1,
    parameter int RX_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_valid,
    output logic               tx_ready,
    input  logic [2*WIDTH-1:0] tx_data,
    input  logic               rx_en,
    output logic               rx_valid,
    output logic [2*WIDTH-1:0] rx_data,
    output logic               busy,
`ifdef IODDR_LOOPBACK_EN
    input  logic               lpbk,
`endif
    inout  wire  [WIDTH-1:0]   dq
);

    localparam int DW = 2 * WIDTH;
    localparam logic [3:0] TURN_LAST = 4'(TURNAROUND - 1);

    // Reject out-of-range parameters at elaboration time.
    if (TURNAROUND < 1 || TURNAROUND > 15) begin : g_bad_turnaround
        $error("ioddr_xfer: TURNAROUND must be 1..15");
    end
    if (RX_LATENCY < 1 || RX_LATENCY > 4) begin : g_bad_rx_latency
        $error("ioddr_xfer: RX_LATENCY must be 1..4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TX   = 2'd1,
        S_RX   = 2'd2,
        S_TURN = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] turn_cnt_q, turn_cnt_d;

    logic          accept;
    logic          oe_q;
    logic [DW-1:0] out_q;
    logic          loop_sel;
    logic          pad_oe;
    logic [WIDTH-1:0] pad_out;

    logic [WIDTH-1:0] cap_hi_q;
    logic             cap_vld;
    logic [DW-1:0]    cap_word;

    logic [RX_LATENCY-1:0]         vld_pipe_q;
    logic [RX_LATENCY-1:0][DW-1:0] pipe_q;

`ifdef IODDR_LOOPBACK_EN
    assign loop_sel = lpbk;
`else
    assign loop_sel = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Direction FSM
    // ------------------------------------------------------------------

    // State and turnaround counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            turn_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            turn_cnt_q <= turn_cnt_d;
        end
    end

    // Next-state logic. TX wins over RX in IDLE, and any tx_valid gap ends a
    // burst. TURN lasts exactly TURNAROUND cycles.
    always_comb begin
        state_d    = state_q;
        turn_cnt_d = turn_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (tx_valid)   state_d = S_TX;
                else if (rx_en) state_d = S_RX;
            end
            S_TX: begin
                if (!tx_valid) begin
                    state_d    = S_TURN;
                    turn_cnt_d = 4'd0;
                end
            end
            S_RX: begin
                if (!rx_en) begin
                    state_d    = S_TURN;
                    turn_cnt_d = 4'd0;
                end
            end
            S_TURN: begin
                if (turn_cnt_q == TURN_LAST) begin
                    state_d    = S_IDLE;
                    turn_cnt_d = 4'd0;
                end else begin
                    turn_cnt_d = turn_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                turn_cnt_d = 4'd0;
            end
        endcase
    end

    // Ready depends on the registered state only, so there is no tx_valid path.
    assign tx_ready = ((state_q == S_IDLE) || (state_q == S_TX)) && !rst;
    assign busy     = (state_q != S_IDLE);
    assign accept   = tx_valid && tx_ready;

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------

    // Register the accepted word. oe is high for exactly the cycle after each accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            oe_q  <= 1'b0;
            out_q <= '0;
        end else begin
            oe_q <= accept;
            if (accept) out_q <= tx_data;
        end
    end

    // DDR output mux. The high half is driven while clk is high, and the low
    // half while clk is low.
    assign pad_out = clk ? out_q[DW-1:WIDTH] : out_q[WIDTH-1:0];
    assign pad_oe  = oe_q && !loop_sel;
    assign dq      = pad_oe ? pad_out : {WIDTH{1'bz}};

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------

    // Sample the high half mid-cycle. This register is only consumed at the
    // following posedge when a capture is valid, so it needs no reset.
    always_ff @(negedge clk) begin
        cap_hi_q <= dq;
    end

    // The capture source is the pads in RX. In loopback, it is the word that
    // the output register holds this cycle.
    assign cap_vld  = loop_sel ? oe_q : (state_q == S_RX);
    assign cap_word = loop_sel ? out_q : {cap_hi_q, dq};

    // Latency pipeline. Data stages load only behind a valid bit, so the
    // last stage holds its word between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            pipe_q     <= '0;
        end else begin
            vld_pipe_q[0] <= cap_vld;
            if (cap_vld) pipe_q[0] <= cap_word;
            for (int i = 1; i < RX_LATENCY; i++) begin
                vld_pipe_q[i] <= vld_pipe_q[i-1];
                if (vld_pipe_q[i-1]) pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign rx_valid = vld_pipe_q[RX_LATENCY-1];
    assign rx_data  = pipe_q[RX_LATENCY-1];

endmodule

// File: tb/tb_ioddr_xfer.sv
`timescale 1ns/1ps
// Bench for ioddr_xfer. Two instances (TURNAROUND=1/RX_LATENCY=1 and
// TURNAROUND=2/RX_LATENCY=3) receive identical stimulus from a per-cycle
// vector table. Receive words go through a scoreboard queue per instance.
module tb_ioddr_xfer;

    localparam int RL0 = 1;
    localparam int RL1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        txv = 1'b0;
    logic        rxen = 1'b0;
    logic [15:0] txd = 16'h0;
`ifdef IODDR_LOOPBACK_EN
    logic        lp = 1'b0;
`endif
    logic        rdy0, rdy1, busy0, busy1, rxv0, rxv1;
    logic [15:0] rxd0, rxd1;
    wire  [7:0]  dq0, dq1;
    logic        bdrv = 1'b0;
    logic [7:0]  bval = 8'h00;

    // Bench-side pad driver. Pull-ups make an undriven bus read as FF.
    assign dq0 = bdrv ? bval : 8'hzz;
    assign dq1 = bdrv ? bval : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (dq0[g]);
        pullup (dq1[g]);
    end

    ioddr_xfer #(.WIDTH(8), .TURNAROUND(1), .RX_LATENCY(RL0)) u_dut0 (
        .clk(clk), .rst(rst), .tx_valid(txv), .tx_ready(rdy0), .tx_data(txd),
        .rx_en(rxen), .rx_valid(rxv0), .rx_data(rxd0), .busy(busy0),
`ifdef IODDR_LOOPBACK_EN
        .lpbk(lp),
`endif
        .dq(dq0));

    ioddr_xfer #(.WIDTH(8), .TURNAROUND(2), .RX_LATENCY(RL1)) u_dut1 (
        .clk(clk), .rst(rst), .tx_valid(txv), .tx_ready(rdy1), .tx_data(txd),
        .rx_en(rxen), .rx_valid(rxv1), .rx_data(rxd1), .busy(busy1),
`ifdef IODDR_LOOPBACK_EN
        .lpbk(lp),
`endif
        .dq(dq1));

    // One row is one clock cycle. Inputs are sampled at the edge that opens
    // the cycle, and the expected values apply during that cycle.
    // Bit 0 of each 2-bit field refers to u_dut0, and bit 1 to u_dut1.
    typedef struct {
        logic        rst, txv, rxen, lp;
        logic [15:0] txd;
        logic        drv;
        logic [7:0]  hi, lo;
        logic [1:0]  cap, bs, rd, oe;
    } vec_t;
    vec_t vecs[$];

    typedef struct {
        int          due;
        logic [15:0] w;
    } exp_t;
    exp_t q0[$], q1[$];
    logic [15:0] last [2];

    int nchk = 0, nfail = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic row(input logic r, input logic tv, input logic re, input logic [15:0] d,
                       input logic dv, input logic [7:0] h, input logic [7:0] l,
                       input logic [1:0] cp, input logic [1:0] bs, input logic [1:0] rd,
                       input logic [1:0] oe, input logic lpv);
        vec_t v;
        v.rst = r; v.txv = tv; v.rxen = re; v.txd = d; v.drv = dv; v.hi = h; v.lo = l;
        v.cap = cp; v.bs = bs; v.rd = rd; v.oe = oe; v.lp = lpv;
        vecs.push_back(v);
    endtask

    // Compare a pad against the DUT word, the bench drive, or pulled-up hi-Z.
    task automatic chk_pads(input vec_t v, input bit lo_ph);
        logic [7:0] e;
        for (int i = 0; i < 2; i++) begin
            if (v.oe[i])    e = lo_ph ? v.txd[7:0] : v.txd[15:8];
            else if (v.drv) e = bval;
            else            e = 8'hFF;
            chk($sformatf("dq%0d_%s", i, lo_ph ? "lo" : "hi"), 32'(i == 0 ? dq0 : dq1), 32'(e));
        end
    endtask

    // Receive monitor. A valid pulse must pop the due word. Otherwise
    // rx_valid must be low and rx_data must hold its last value.
    task automatic chk_rx(input int i, input logic v, input logic [15:0] d);
        exp_t e;
        bit   have;
        have = 0;
        if (i == 0 && q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); have = 1; end
        if (i == 1 && q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); have = 1; end
        if (have) begin
            chk($sformatf("rx_valid%0d", i), 32'(v), 32'd1);
            chk($sformatf("rx_data%0d", i), 32'(d), 32'(e.w));
            last[i] = e.w;
        end else begin
            chk($sformatf("rx_idle%0d", i), 32'(v), 32'd0);
            chk($sformatf("rx_hold%0d", i), 32'(d), 32'(last[i]));
        end
    endtask

    initial begin
        last[0] = 16'h0;
        last[1] = 16'h0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            chk_rx(0, rxv0, rxd0);
            chk_rx(1, rxv1, rxd1);
        end
    end

    initial begin
        //   rst tv re txd       drv hi     lo     cap    busy   rdy    oe     lp
        row(1, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0); // reset state
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 2'b00, 0);
        // three-word burst, then TURN (1 cycle vs 2 cycles)
        row(0, 1, 0, 16'hA1B2, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b11, 0);
        row(0, 1, 0, 16'hC3D4, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b11, 0);
        row(0, 1, 0, 16'hE5F6, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b11, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b10, 2'b01, 2'b00, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 2'b00, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 2'b00, 0);
        // two-word read
        row(0, 0, 1, 16'h0000, 1, 8'h11, 8'h22, 2'b11, 2'b11, 2'b00, 2'b00, 0);
        row(0, 0, 1, 16'h0000, 1, 8'h33, 8'h44, 2'b11, 2'b11, 2'b00, 2'b00, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b10, 2'b01, 2'b00, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 2'b00, 0);
        // tx_valid and rx_en together: TX first, then TURN, IDLE, RX
        row(0, 1, 1, 16'h1357, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b11, 0);
        row(0, 1, 1, 16'h2468, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b11, 0);
        row(0, 0, 1, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 0);
        row(0, 0, 1, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b10, 2'b01, 2'b00, 0);
        row(0, 0, 1, 16'h0000, 1, 8'h5A, 8'hA5, 2'b01, 2'b01, 2'b10, 2'b00, 0);
        row(0, 0, 1, 16'h0000, 1, 8'h66, 8'h77, 2'b11, 2'b11, 2'b00, 2'b00, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b10, 2'b01, 2'b00, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 2'b00, 0);
        // tx_valid held during TURN: no accept until IDLE
        row(0, 1, 0, 16'hAAAA, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b11, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 0);
        row(0, 1, 0, 16'hBBBB, 0, 8'h00, 8'h00, 2'b00, 2'b10, 2'b01, 2'b00, 0);
        row(0, 1, 0, 16'hBBBB, 0, 8'h00, 8'h00, 2'b00, 2'b01, 2'b11, 2'b01, 0);
        row(0, 1, 0, 16'hCCCC, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b11, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b10, 2'b01, 2'b00, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 2'b00, 0);
        // reset during the second word of a burst
        row(0, 1, 0, 16'h1111, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b11, 0);
        row(0, 1, 0, 16'h2222, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b11, 2'b11, 0);
        row(1, 1, 0, 16'h3333, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 2'b00, 0);
`ifdef IODDR_LOOPBACK_EN
        // loopback: pads stay hi-Z, and TX words return through the RX pipeline
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 2'b00, 1);
        row(0, 1, 0, 16'h5AA5, 0, 8'h5A, 8'hA5, 2'b11, 2'b11, 2'b11, 2'b00, 1);
        row(0, 1, 0, 16'h0FF0, 0, 8'h0F, 8'hF0, 2'b11, 2'b11, 2'b11, 2'b00, 1);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b11, 2'b00, 2'b00, 1);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b10, 2'b01, 2'b00, 1);
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 2'b00, 1);
`endif
        row(0, 0, 0, 16'h0000, 0, 8'h00, 8'h00, 2'b00, 2'b00, 2'b11, 2'b00, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            vec_t v;
            v = vecs[k];
            rst = v.rst; txv = v.txv; rxen = v.rxen; txd = v.txd;
`ifdef IODDR_LOOPBACK_EN
            lp = v.lp;
`endif
            if (v.rst) begin
                q0.delete();
                q1.delete();
                last[0] = 16'h0;
                last[1] = 16'h0;
            end
            @(posedge clk);
            #1;
            bdrv = v.drv;
            bval = v.hi;
            if (v.cap[0]) q0.push_back('{cyc + RL0, {v.hi, v.lo}});
            if (v.cap[1]) q1.push_back('{cyc + RL1, {v.hi, v.lo}});
            #1;
            chk("busy0", 32'(busy0), 32'(v.bs[0]));
            chk("busy1", 32'(busy1), 32'(v.bs[1]));
            chk("tx_ready0", 32'(rdy0), 32'(v.rd[0]));
            chk("tx_ready1", 32'(rdy1), 32'(v.rd[1]));
            chk_pads(v, 1'b0);
            @(negedge clk);
            #1;
            bval = v.lo;
            #1;
            chk_pads(v, 1'b1);
        end

        rst = 1'b0; txv = 1'b0; rxen = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        bdrv = 1'b0;
        chk("sb0_drained", 32'(q0.size()), 32'd0);
        chk("sb1_drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
